pipe_result_sink: RTL

- Receiving end of a fixed-latency, non-stallable FPU datapath whose stages are plain delay lines.
- Tracks operations issued into the pipe and buffers results as they emerge, in a first-word-fall-through FIFO.
- Presents results downstream with a valid/ready handshake.
- Grants issue credits upstream, so a result leaving the pipe always has a free FIFO slot.

---
 rtl/pipe_result_sink.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipe_result_sink.sv
// Result sink for a fixed-latency, non-stallable pipe: a FWFT FIFO with credit-based issue control.
// A result is on o_d one cycle after it is written; upstream stalls only through o_issue_ok.
module pipe_result_sink #(
    parameter int DW    = 32,
    parameter int LAT   = 12,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_issue,
    output logic                         o_issue_ok,
    input  logic                         i_valid,
    input  logic [DW-1:0]                i_d,
    output logic                         o_valid,
    output logic [DW-1:0]                o_d,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
    output logic                         o_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {FLUSH, RUN} state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [DW-1:0]  mem [DEPTH];
    logic           err_q;

    logic           run, pop, full, wr_en, issue_c, valid_c, ret, err_set;
    logic [CW:0]    sum, infl_ext;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The delay lines upstream are not reset, so their stale contents drain during FLUSH.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            FLUSH: begin
                if (fcnt_q <= FW'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q - 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = FLUSH;
        endcase
    end

    always_comb begin
        run        = (state_q == RUN);
        sum        = {1'b0, count_q} + {1'b0, inflight_q};
        o_issue_ok = run && (sum < (CW+1)'(DEPTH));
        o_valid    = (count_q != '0);
        o_d        = mem[rd_ptr];
        pop        = o_valid & i_ready;
        full       = (count_q == CW'(DEPTH));
        issue_c    = run & i_issue;
        valid_c    = run & i_valid;
        wr_en      = valid_c & (~full | pop);
        // With LAT=0 a result may return in its own issue cycle.
        ret        = valid_c & ((inflight_q != '0) | issue_c);
        infl_ext   = {1'b0, inflight_q} + (CW+1)'(issue_c) - (CW+1)'(ret);
        inflight_d = (infl_ext > (CW+1)'(DEPTH)) ? CW'(DEPTH) : infl_ext[CW-1:0];
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        err_set    = (issue_c & ~o_issue_ok)
                   | (valid_c & (inflight_q == '0) & ~issue_c)
                   | (valid_c & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FLUSH;
            fcnt_q     <= FW'(LAT);
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (wr_en) wr_ptr <= bump(wr_ptr);
            if (pop)   rd_ptr <= bump(rd_ptr);
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= i_d;
    end

    assign o_count    = count_q;
    assign o_inflight = inflight_q;
    assign o_err      = err_q;
endmodule
